branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer (BTB) in the fetch stage, one stage upstream of the decode-stage branch controller. Looked up every cycle with the fetch PC; on a hit with a taken prediction, fetch redirects to the stored target before decode has even identified the branch. Trained from execute-stage branch results. Contains a sequential flush sweep so software or the hazard unit can invalidate the table without a reset.

---
 rtl/branch_target_buffer.sv | 156 +++++++++++++++
 tb/tb_branch_target_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage.
// Lookup is combinational. Execute-stage results train the table. A flush
// starts a sweep that clears one valid bit per cycle.
// Optional feature macro: BTB_2BIT_COUNTER_EN selects 2-bit saturating
// counters. When it is not defined, each entry has a 1-bit last-outcome bit.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer #(
    parameter int INDEX_WIDTH = 6,
    parameter int ADDR_WIDTH  = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                  o_hit,
    output logic                  o_predict_taken,
    output logic [ADDR_WIDTH-1:0] o_target,
    input  logic                  i_update_valid,
    input  logic [ADDR_WIDTH-1:0] i_update_pc,
    input  logic [ADDR_WIDTH-1:0] i_update_target,
    input  logic                  i_update_taken,
    input  logic                  i_update_is_jump,
    input  logic                  i_flush,
    output logic                  o_busy
);

    localparam int ENTRIES   = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
`ifdef BTB_2BIT_COUNTER_EN
    localparam int CNT_WIDTH = 2;
`else
    localparam int CNT_WIDTH = 1;
`endif
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ALLOC = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [ENTRIES-1:0]     valid_q, valid_d;

    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [CNT_WIDTH-1:0]  cnt_q    [ENTRIES];

    logic [INDEX_WIDTH-1:0] lk_idx, up_idx;
    logic [TAG_WIDTH-1:0]   lk_tag, up_tag;
    logic                   up_hit;
    logic [CNT_WIDTH-1:0]   cur_cnt;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_target;
    logic [CNT_WIDTH-1:0]  wr_cnt;

    // The two low PC bits never take part in indexing or tag compare.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

    assign lk_idx  = i_lookup_pc[INDEX_WIDTH+1:2];
    assign lk_tag  = i_lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign up_idx  = i_update_pc[INDEX_WIDTH+1:2];
    assign up_tag  = i_update_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign cur_cnt = cnt_q[up_idx];

    // Lookup: a hit needs a valid matching entry outside of a sweep.
    always_comb begin
        o_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && (state_q == IDLE);
        o_predict_taken = o_hit && cnt_q[lk_idx][CNT_WIDTH-1];
        o_target        = o_hit ? target_q[lk_idx] : '0;
        o_busy          = (state_q == SWEEP);
    end

    // Next state for the sweep FSM, the valid bits and the table write port.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        wr_en     = 1'b0;
        wr_target = target_q[up_idx];
        wr_cnt    = cur_cnt;
        unique case (state_q)
            IDLE: begin
                if (i_flush) begin
                    // The flush wins over an update arriving in the same cycle.
                    state_d = SWEEP;
                    idx_d   = '0;
                end else if (i_update_valid) begin
                    if (up_hit) begin
                        wr_en = 1'b1;
                        if (i_update_is_jump) begin
                            wr_cnt    = CNT_MAX;
                            wr_target = i_update_target;
                        end else if (i_update_taken) begin
                            wr_cnt    = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
                            wr_target = i_update_target;
                        end else begin
                            wr_cnt = (cur_cnt == '0) ? cur_cnt : cur_cnt - 1'b1;
                        end
                    end else if (i_update_taken || i_update_is_jump) begin
                        // Allocate, replacing whatever alias held this index.
                        wr_en           = 1'b1;
                        valid_d[up_idx] = 1'b1;
                        wr_target       = i_update_target;
                        wr_cnt          = i_update_is_jump ? CNT_MAX : CNT_ALLOC;
                    end
                end
            end
            SWEEP: begin
                valid_d[idx_q] = 1'b0;
                if (i_flush) begin
                    idx_d = '0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and valid bits, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    // Table payload; contents behind a cleared valid bit are never observed.
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays are deliberately not reset so they map onto plain RAM.
        if (wr_en) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= wr_target;
            cnt_q[up_idx]    <= wr_cnt;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// Expected values are hand-computed; the counter scenario follows
// BTB_2BIT_COUNTER_EN when it is defined.
`timescale 1ns/1ps

module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_lookup_pc;
    logic        o_hit;
    logic        o_predict_taken;
    logic [31:0] o_target;
    logic        i_update_valid;
    logic [31:0] i_update_pc;
    logic [31:0] i_update_target;
    logic        i_update_taken;
    logic        i_update_is_jump;
    logic        i_flush;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;

    branch_target_buffer #(.INDEX_WIDTH(6), .ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_lookup_pc      (i_lookup_pc),
        .o_hit            (o_hit),
        .o_predict_taken  (o_predict_taken),
        .o_target         (o_target),
        .i_update_valid   (i_update_valid),
        .i_update_pc      (i_update_pc),
        .i_update_target  (i_update_target),
        .i_update_taken   (i_update_taken),
        .i_update_is_jump (i_update_is_jump),
        .i_flush          (i_flush),
        .o_busy           (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a lookup mid-cycle and compare all three lookup outputs.
    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic pt, input logic [31:0] tgt);
        i_lookup_pc = pc;
        #1;
        check({tag, ".hit"}, {31'd0, o_hit}, {31'd0, hit});
        check({tag, ".pt"}, {31'd0, o_predict_taken}, {31'd0, pt});
        check({tag, ".tgt"}, o_target, tgt);
    endtask

    // One-cycle update pulse; returns just after the following falling edge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic taken, input logic jump);
        @(negedge clk);
        i_update_valid   = 1'b1;
        i_update_pc      = pc;
        i_update_target  = tgt;
        i_update_taken   = taken;
        i_update_is_jump = jump;
        @(negedge clk);
        i_update_valid   = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        i_lookup_pc      = 32'h0040_0108;
        i_update_valid   = 1'b0;
        i_update_pc      = '0;
        i_update_target  = '0;
        i_update_taken   = 1'b0;
        i_update_is_jump = 1'b0;
        i_flush          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        look("reset", 32'h0040_0108, 1'b0, 1'b0, 32'h0);
        check("reset.busy", {31'd0, o_busy}, 32'd0);

        // Allocate a taken branch, visible the next cycle.
        upd(32'h0040_0108, 32'h0040_0040, 1'b1, 1'b0);
        look("alloc", 32'h0040_0108, 1'b1, 1'b1, 32'h0040_0040);

        // Not-taken update; the same-cycle lookup still sees the old counter.
        @(negedge clk);
        i_update_valid   = 1'b1;
        i_update_pc      = 32'h0040_0108;
        i_update_target  = 32'h0040_0999;
        i_update_taken   = 1'b0;
        i_update_is_jump = 1'b0;
        look("same_cycle", 32'h0040_0108, 1'b1, 1'b1, 32'h0040_0040);
        @(negedge clk);
        i_update_valid = 1'b0;
        // Target is kept on a not-taken update.
        look("nt1", 32'h0040_0108, 1'b1, 1'b0, 32'h0040_0040);
`ifdef BTB_2BIT_COUNTER_EN
        upd(32'h0040_0108, 32'h0040_0040, 1'b0, 1'b0);
        look("nt2", 32'h0040_0108, 1'b1, 1'b0, 32'h0040_0040);
        upd(32'h0040_0108, 32'h0040_0040, 1'b1, 1'b0);
        look("t1", 32'h0040_0108, 1'b1, 1'b0, 32'h0040_0040);
        upd(32'h0040_0108, 32'h0040_0040, 1'b1, 1'b0);
        look("t2", 32'h0040_0108, 1'b1, 1'b1, 32'h0040_0040);
`else
        upd(32'h0040_0108, 32'h0040_0040, 1'b1, 1'b0);
        look("t1", 32'h0040_0108, 1'b1, 1'b1, 32'h0040_0040);
`endif

        // Jump allocation at index 63.
        upd(32'h0040_01FC, 32'h0050_0000, 1'b0, 1'b1);
        look("jump63", 32'h0040_01FC, 1'b1, 1'b1, 32'h0050_0000);

        // Alias at index 2 replaces the earlier entry.
        upd(32'h0040_0208, 32'h0040_0300, 1'b1, 1'b0);
        look("alias_old", 32'h0040_0108, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h0040_0208, 1'b1, 1'b1, 32'h0040_0300);

        // Index 0; then a not-taken miss must not allocate.
        upd(32'h0040_0100, 32'h0040_0500, 1'b1, 1'b0);
        look("idx0", 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0500);
        upd(32'h0040_0010, 32'h0040_0600, 1'b0, 1'b0);
        look("nt_miss", 32'h0040_0010, 1'b0, 1'b0, 32'h0);

        // Flush pulse with a coinciding update: the update is dropped.
        @(negedge clk);
        i_flush          = 1'b1;
        i_update_valid   = 1'b1;
        i_update_pc      = 32'h0040_0004;
        i_update_target  = 32'h0040_0700;
        i_update_taken   = 1'b1;
        i_update_is_jump = 1'b0;
        @(negedge clk);
        i_flush        = 1'b0;
        i_update_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check($sformatf("sweep_busy[%0d]", k), {31'd0, o_busy}, 32'd1);
            i_lookup_pc = (k % 2 == 0) ? 32'h0040_01FC : 32'h0040_0208;
            #1;
            check($sformatf("sweep_hit[%0d]", k), {31'd0, o_hit}, 32'd0);
            if (k == 20) begin
                // Index 5 is already swept; a leaked write would survive.
                i_update_valid   = 1'b1;
                i_update_pc      = 32'h0040_0014;
                i_update_target  = 32'h0040_0800;
                i_update_taken   = 1'b1;
                i_update_is_jump = 1'b1;
            end else begin
                i_update_valid = 1'b0;
            end
            @(negedge clk);
        end
        i_update_valid = 1'b0;
        check("sweep_done_busy", {31'd0, o_busy}, 32'd0);
        look("post_idx0", 32'h0040_0100, 1'b0, 1'b0, 32'h0);
        look("post_idx2", 32'h0040_0208, 1'b0, 1'b0, 32'h0);
        look("post_idx63", 32'h0040_01FC, 1'b0, 1'b0, 32'h0);
        look("post_midsweep", 32'h0040_0014, 1'b0, 1'b0, 32'h0);
        look("post_flushupd", 32'h0040_0004, 1'b0, 1'b0, 32'h0);

        // Refill index 63, then reset in the middle of a second sweep.
        upd(32'h0040_01FC, 32'h0050_0000, 1'b1, 1'b0);
        look("refill63", 32'h0040_01FC, 1'b1, 1'b1, 32'h0050_0000);
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        repeat (10) @(negedge clk);
        check("sweep2_busy", {31'd0, o_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        look("rst_look", 32'h0040_01FC, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        look("after_rst63", 32'h0040_01FC, 1'b0, 1'b0, 32'h0);
        check("after_rst_busy", {31'd0, o_busy}, 32'd0);
        upd(32'h0040_0108, 32'h0040_0040, 1'b1, 1'b0);
        look("after_rst_alloc", 32'h0040_0108, 1'b1, 1'b1, 32'h0040_0040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
